// File: rtl/mul_share_sched_if.sv
// mul_share_sched_if: bus bundle between the requesters, the shared-multiplier
// scheduler and the multiplier core.
//   slave  modport : scheduler side (takes req/operands/core status, drives
//                    grants, done, result, err and the core start/operands)
//   master modport : environment side (requesters plus core)
// Parameters: N_REQ requesters, W-bit operands, 2*W-bit product.
interface mul_share_sched_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 8
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] a_in;
   logic [N_REQ*W-1:0] b_in;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   done;
   logic [2*W-1:0]     result;
   logic               err;
   logic               core_bgn;
   logic [W-1:0]       core_x;
   logic [W-1:0]       core_y;
   logic               core_fin;
   logic [2*W-1:0]     core_prod;

   modport slave (
      input  req, a_in, b_in, core_fin, core_prod,
      output gnt, done, result, err, core_bgn, core_x, core_y
   );

   modport master (
      output req, a_in, b_in, core_fin, core_prod,
      input  gnt, done, result, err, core_bgn, core_x, core_y
   );
endinterface

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one sequential multiplier core
// among N_REQ requesters. Latches the winner's operands, pulses core_bgn, waits
// for core_fin, captures the product and returns it with a one-cycle done pulse.
// Ports:
//   clk    : clock, rising edge
//   rst_b  : synchronous active-low reset (shared with the core)
//   bus    : mul_share_sched_if.slave (req/a_in/b_in/core_fin/core_prod in;
//            gnt/done/result/err/core_bgn/core_x/core_y out, all registered)
// Optional feature: define MUL_SCHED_TIMEOUT_EN to add a WAIT/DRAIN watchdog
// that aborts after TIMEOUT cycles with err and a zero result.
module mul_share_sched #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned W       = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst_b,
   mul_share_sched_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_param_chk
      $error("mul_share_sched: unsupported parameter set");
   end

`ifdef MUL_SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   typedef enum logic [5:0] {
      IDLE    = 6'b000001,
      LAUNCH  = 6'b000010,
      WAIT    = 6'b000100,
      DRAIN   = 6'b001000,
      DELIVER = 6'b010000,
      ABORT   = 6'b100000
   } state_t;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo;
`else
   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      LAUNCH  = 5'b00010,
      WAIT    = 5'b00100,
      DRAIN   = 5'b01000,
      DELIVER = 5'b10000
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  win_q, win_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  done_q, done_d;
   logic [2*W-1:0]    result_q, result_d;
   logic              err_q, err_d;
   logic              core_bgn_q, core_bgn_d;
   logic [W-1:0]      core_x_q, core_x_d;
   logic [W-1:0]      core_y_q, core_y_d;

   // Round-robin pick: first requester at or after ptr+1, wrapping.
   logic              found;
   logic [IDX_W-1:0]  pick;
   logic [IDX_W-1:0]  cand;
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef MUL_SCHED_TIMEOUT_EN
   // Watchdog reaches TIMEOUT on the edge that leaves WAIT/DRAIN for ABORT.
   assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      result_d   = result_q;
      err_d      = 1'b0;
      core_bgn_d = 1'b0;
      core_x_d   = core_x_q;
      core_y_d   = core_y_q;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = LAUNCH;
               win_d        = pick;
               gnt_d        = '0;
               gnt_d[pick]  = 1'b1;
               core_bgn_d   = 1'b1;
               core_x_d     = bus.a_in[32'(pick)*W +: W];
               core_y_d     = bus.b_in[32'(pick)*W +: W];
            end
         end
         LAUNCH: begin
            state_d = WAIT;
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (bus.core_fin) begin
               state_d  = DRAIN;
               result_d = bus.core_prod;
            end
`ifdef MUL_SCHED_TIMEOUT_EN
            else if (tmo) begin
               state_d  = ABORT;
               result_d = '0;
               err_d    = 1'b1;
               done_d   = gnt_q;
            end
`endif
         end
         DRAIN: begin
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            // Deliver only once the core has dropped fin and is idle again.
            if (!bus.core_fin) begin
               state_d = DELIVER;
               done_d  = gnt_q;
            end
`ifdef MUL_SCHED_TIMEOUT_EN
            else if (tmo) begin
               state_d  = ABORT;
               result_d = '0;
               err_d    = 1'b1;
               done_d   = gnt_q;
            end
`endif
         end
         DELIVER: begin
            state_d = IDLE;
            ptr_d   = win_q;
            gnt_d   = '0;
         end
`ifdef MUL_SCHED_TIMEOUT_EN
         ABORT: begin
            state_d = IDLE;
            ptr_d   = win_q;
            gnt_d   = '0;
         end
`endif
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         ptr_q      <= IDX_W'(N_REQ - 1);
         win_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         core_bgn_q <= 1'b0;
         core_x_q   <= '0;
         core_y_q   <= '0;
`ifdef MUL_SCHED_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         err_q      <= err_d;
         core_bgn_q <= core_bgn_d;
         core_x_q   <= core_x_d;
         core_y_q   <= core_y_d;
`ifdef MUL_SCHED_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.err      = err_q;
   assign bus.core_bgn = core_bgn_q;
   assign bus.core_x   = core_x_q;
   assign bus.core_y   = core_y_q;

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Round-robin scheduler that shares one sequential multiplier core (start/finish handshake, multi-cycle latency) among N_REQ requesters. It sits between the requesting units and the core. It latches the winning requester's operands, launches the core, and waits for completion. It then returns the product with a one-cycle done pulse to that requester. Operands and product pass through uninterpreted; signedness is the core's concern.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand width; product is 2*W
- TIMEOUT, 64, watchdog limit in cycles; used only with MUL_SCHED_TIMEOUT_EN
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  reset, synchronous and active-low; shared with the core
- req  in  N_REQ  per-requester request level
- a_in  in  N_REQ*W  operand A, requester i at bits [i*W +: W]
- b_in  in  N_REQ*W  operand B, same packing
- gnt  out  N_REQ  one-hot grant, high from LAUNCH through DELIVER
- done  out  N_REQ  one-cycle pulse to the granted requester; result valid
- result  out  2*W  product register, holds until next capture
- err  out  1  high with done when the operation timed out
- core_bgn  out  1  one-cycle start pulse to core
- core_x, core_y  out  W  operands to core, registered, stable LAUNCH..DRAIN
- core_fin  in  1  core finish level (may stay high several cycles)
- core_prod  in  2*W  core product, valid while core_fin high

## Operation
- States: IDLE, LAUNCH, WAIT, DRAIN, DELIVER (plus ABORT with macro). One-hot encoded.
- IDLE: if any req is high, select the winner by round-robin. The search starts at ptr+1 mod N_REQ. Latch its a/b into core_x/core_y, latch winner index, go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: core_bgn=1, gnt[win]=1 → WAIT.
- WAIT: on core_fin=1, latch core_prod into result → DRAIN.
- DRAIN: stay while core_fin=1. On core_fin=0 (core back in its idle state) → DELIVER.
- DELIVER: done[win]=1, ptr←win → IDLE.
- Only one operation is ever in flight. Requests arriving outside IDLE wait; req is a level and is re-evaluated next IDLE.
- A requester must hold req and operands until done. If req drops after selection, the operation still completes and done still pulses.
- Simultaneous requests: exactly one gnt bit; the others are untouched.
- ptr reset value = N_REQ-1, so requester 0 wins the first contention.

## Timing
- Reset (rst_b=0 at a rising edge): state=IDLE, gnt=0, done=0, err=0, core_bgn=0, core_x=core_y=0, result=0, ptr=N_REQ-1.
- Reset mid-operation aborts without done. The core resets on the same rst_b.
- req high in IDLE at edge k → LAUNCH at k+1 (core_bgn, gnt high), WAIT at k+2.
- First core_fin=1 sampled at edge m → result updated, DRAIN at m+1.
- core_fin low sampled at edge d → DELIVER at d+1, done high that cycle, IDLE at d+2.
- Minimum gap between two consecutive core_bgn pulses: 3 cycles plus core latency plus fin duration.
- result changes only on a WAIT capture (or on ABORT with the macro defined).

## Configuration
- MUL_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT/DRAIN and clears at LAUNCH.
  - On count = TIMEOUT → ABORT: result←0, err=1 and done[win]=1 for one cycle, ptr←win → IDLE.
  - err is otherwise 0.
- Not defined:
  - No counter and no ABORT state; err is tied 0.
  - WAIT/DRAIN wait indefinitely for core_fin.

## Test plan
- Single request: req=0001, a=3, b=5 → one core_bgn pulse, gnt=0001; after core_fin, result=0x000F, done=0001 for one cycle, err=0.
- Contention: req=0101, operand pairs (2,4) and (-3,7) → requester 0 served first (result 0x0008), then requester 2 (result 0xFFEB); gnt is never multi-hot.
- Fairness: req=1111 held continuously → grant order 0,1,2,3,0; each done is matched to its own operands.
- Reset in WAIT: assert rst_b=0 for one cycle → next cycle all outputs are 0, state is IDLE; next request wins from requester 0.
- Long core_fin: fin held high 2 cycles → exactly one done; next core_bgn occurs only after fin is low.
- With MUL_SCHED_TIMEOUT_EN, core_fin stuck 0 → done and err pulse exactly 64 cycles after WAIT entry, result=0; next pending requester is served normally.
